// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60 Hz VGA timing generator.
// Divides reloj down to a pixel tick, runs the Qh/Qv pixel/line counters and
// produces registered hsync/vsync/video_on/frame_start aligned with Qh/Qv.
// Optional feature macro: VGA_BLINK_EN (frame-counted blink toggle).
// Without VGA_BLINK_EN the blink output is tied low.
module vga_sync_gen #(
  parameter int CLK_DIV      = 4,
  parameter int H_DISPLAY    = 640,
  parameter int H_FRONT      = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BACK       = 48,
  parameter int V_DISPLAY    = 480,
  parameter int V_FRONT      = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BACK       = 33,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       reloj,
  input  logic       resetM,
  output logic       pixel_tick,
  output logic [9:0] Qh,
  output logic [9:0] Qv,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_start,
  output logic       blink
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  // Parameter sanity: counters are 10 bits wide, divider needs at least 2 phases.
  if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 2 || CLK_DIV > 16 ||
      BLINK_FRAMES < 1) begin : g_bad_params
    $error("vga_sync_gen: illegal parameter set");
  end

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

  // 11-bit bounds so a sync window ending exactly at 1024 is still representable.
  localparam logic [10:0] H_VIS_END = 11'(H_DISPLAY);
  localparam logic [10:0] HS_START  = 11'(H_DISPLAY + H_FRONT);
  localparam logic [10:0] HS_END    = 11'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [10:0] V_VIS_END = 11'(V_DISPLAY);
  localparam logic [10:0] VS_START  = 11'(V_DISPLAY + V_FRONT);
  localparam logic [10:0] VS_END    = 11'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;
  logic [9:0]       qh_q, qh_d;
  logic [9:0]       qv_q, qv_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             vid_q, vid_d;
  logic             fs_q, fs_d;
  logic [10:0]      qh_x;
  logic [10:0]      qv_x;

  // Clock divider: tick is registered, so it is high the cycle after div hits CLK_DIV-1.
  always_comb begin
    div_d  = div_q + DIV_W'(1);
    tick_d = 1'b0;
    if (div_q == DIV_LAST) begin
      div_d  = '0;
      tick_d = 1'b1;
    end
  end

  // Pixel/line counters plus decode computed from the next counter values.
  always_comb begin
    qh_d  = qh_q;
    qv_d  = qv_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    vid_d = vid_q;
    fs_d  = 1'b0;
    if (tick_q) begin
      if (qh_q == H_LAST) begin
        qh_d = '0;
        if (qv_q == V_LAST) begin
          qv_d = '0;
          fs_d = 1'b1;
        end else begin
          qv_d = qv_q + 10'd1;
        end
      end else begin
        qh_d = qh_q + 10'd1;
      end
    end
    qh_x = {1'b0, qh_d};
    qv_x = {1'b0, qv_d};
    if (tick_q) begin
      hs_d  = !((qh_x >= HS_START) && (qh_x < HS_END));
      vs_d  = !((qv_x >= VS_START) && (qv_x < VS_END));
      vid_d = (qh_x < H_VIS_END) && (qv_x < V_VIS_END);
    end
  end

  // State register with synchronous active-low reset; reset aborts any frame in progress.
  always_ff @(posedge reloj) begin
    if (!resetM) begin
      div_q  <= '0;
      tick_q <= 1'b0;
      qh_q   <= '0;
      qv_q   <= '0;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      vid_q  <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
      qh_q   <= qh_d;
      qv_q   <= qv_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      vid_q  <= vid_d;
      fs_q   <= fs_d;
    end
  end

  assign pixel_tick  = tick_q;
  assign Qh          = qh_q;
  assign Qv          = qv_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign video_on    = vid_q;
  assign frame_start = fs_q;

`ifdef VGA_BLINK_EN
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

  logic [FC_W-1:0] fcnt_q, fcnt_d;
  logic            blink_q, blink_d;

  // Frame counter: on the frame_start that finds it at BLINK_FRAMES-1, wrap and toggle blink.
  always_comb begin
    fcnt_d  = fcnt_q;
    blink_d = blink_q;
    if (fs_q) begin
      if (fcnt_q == FC_LAST) begin
        fcnt_d  = '0;
        blink_d = ~blink_q;
      end else begin
        fcnt_d = fcnt_q + FC_W'(1);
      end
    end
  end

  // Blink state register.
  always_ff @(posedge reloj) begin
    if (!resetM) begin
      fcnt_q  <= '0;
      blink_q <= 1'b0;
    end else begin
      fcnt_q  <= fcnt_d;
      blink_q <= blink_d;
    end
  end

  assign blink = blink_q;
`else
  assign blink = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Testbench for vga_sync_gen.
// dut_a uses the default 640x480 timing for reset, tick and line checks.
// dut_s uses a shrunken raster (15x12, CLK_DIV=2) so several whole frames fit in a short run.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_s;
  logic       tick_a, hs_a, vs_a, vid_a, fs_a, blink_a;
  logic [9:0] qh_a, qv_a;
  logic       tick_s, hs_s, vs_s, vid_s, fs_s, blink_s;
  logic [9:0] qh_s, qv_s;

  vga_sync_gen dut_a (
    .reloj(clk), .resetM(rst_a), .pixel_tick(tick_a), .Qh(qh_a), .Qv(qv_a),
    .hsync(hs_a), .vsync(vs_a), .video_on(vid_a), .frame_start(fs_a), .blink(blink_a)
  );

  vga_sync_gen #(
    .CLK_DIV(2), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2), .BLINK_FRAMES(2)
  ) dut_s (
    .reloj(clk), .resetM(rst_s), .pixel_tick(tick_s), .Qh(qh_s), .Qv(qv_s),
    .hsync(hs_s), .vsync(vs_s), .video_on(vid_s), .frame_start(fs_s), .blink(blink_s)
  );

  typedef struct {
    int   ticks;
    int   qh;
    int   qv;
    logic hs;
    logic vs;
    logic vid;
  } vec_t;

  vec_t vecs[12];

  int n_vec = 0;
  int n_err = 0;
  int t_ticks, cyc_a, hs_low;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance dut_a by one pixel tick, checking tick spacing and width on the way.
  task automatic step_a();
    do begin
      @(negedge clk);
      cyc_a++;
    end while (tick_a !== 1'b1 && cyc_a < 20);
    if (tick_a !== 1'b1) begin
      n_vec++;
      n_err++;
      if (n_err <= 40) $display("FAIL tick_timeout: got no tick after %0d cycles expected 4", cyc_a);
      cyc_a = 0;
      t_ticks++;
      return;
    end
    check("tick_gap", cyc_a, 4);
    cyc_a = 0;
    @(negedge clk);
    cyc_a = 1;
    check("tick_width", tick_a, 0);
    t_ticks++;
    if (t_ticks <= 800 && hs_a === 1'b0) hs_low++;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   eqh, eqv, fs_cnt, fcnt;
    logic prev_tick, prev_fs, started, exp_blink, wrap, blink_hand;

    vecs[0]  = '{1,    1,   0, 1'b1, 1'b1, 1'b1};
    vecs[1]  = '{639,  639, 0, 1'b1, 1'b1, 1'b1};
    vecs[2]  = '{640,  640, 0, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{655,  655, 0, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{656,  656, 0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{751,  751, 0, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{752,  752, 0, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{799,  799, 0, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{800,  0,   1, 1'b1, 1'b1, 1'b1};
    vecs[9]  = '{801,  1,   1, 1'b1, 1'b1, 1'b1};
    vecs[10] = '{1700, 100, 2, 1'b1, 1'b1, 1'b1};
    vecs[11] = '{2399, 799, 2, 1'b1, 1'b1, 1'b0};

    // Reset held for 5 cycles.
    rst_a = 1'b0;
    rst_s = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_tick", tick_a, 0);
    check("rst_qh", qh_a, 0);
    check("rst_qv", qv_a, 0);
    check("rst_hsync", hs_a, 1);
    check("rst_vsync", vs_a, 1);
    check("rst_video", vid_a, 0);
    check("rst_fs", fs_a, 0);
    check("rst_blink", blink_a, 0);
    check("rst_s_hsync", hs_s, 1);
    check("rst_s_vsync", vs_s, 1);

    // Release; before the first tick (0,0) shows video_on = 0.
    rst_a   = 1'b1;
    cyc_a   = 0;
    t_ticks = 0;
    hs_low  = 0;
    @(negedge clk);
    cyc_a = 1;
    check("pre_tick_video", vid_a, 0);
    check("pre_tick_qh", qh_a, 0);

    for (int i = 0; i < 12; i++) begin
      while (t_ticks < vecs[i].ticks) step_a();
      check($sformatf("vec%0d_qh", i), qh_a, vecs[i].qh);
      check($sformatf("vec%0d_qv", i), qv_a, vecs[i].qv);
      check($sformatf("vec%0d_hsync", i), hs_a, vecs[i].hs);
      check($sformatf("vec%0d_vsync", i), vs_a, vecs[i].vs);
      check($sformatf("vec%0d_video", i), vid_a, vecs[i].vid);
      check($sformatf("vec%0d_fs", i), fs_a, 0);
    end
    check("hsync_low_ticks", hs_low, 96);

    // Mid-line reset inside the hsync pulse.
    while (t_ticks < 3100) step_a();
    check("pre_rst_qh", qh_a, 700);
    check("pre_rst_qv", qv_a, 3);
    check("pre_rst_hsync", hs_a, 0);
    rst_a = 1'b0;
    @(negedge clk);
    check("mid_rst_qh", qh_a, 0);
    check("mid_rst_qv", qv_a, 0);
    check("mid_rst_hsync", hs_a, 1);
    check("mid_rst_vsync", vs_a, 1);
    check("mid_rst_video", vid_a, 0);
    check("mid_rst_tick", tick_a, 0);
    rst_a   = 1'b1;
    cyc_a   = 0;
    t_ticks = 0;
    step_a();
    check("post_rst_qh", qh_a, 1);
    check("post_rst_qv", qv_a, 0);
    check("post_rst_video", vid_a, 1);

    // Whole-frame run on the small raster.
`ifdef VGA_BLINK_EN
    blink_hand = 1'b1;
`else
    blink_hand = 1'b0;
`endif
    rst_s     = 1'b1;
    eqh       = 0;
    eqv       = 0;
    fs_cnt    = 0;
    fcnt      = 0;
    prev_tick = 1'b0;
    prev_fs   = 1'b0;
    started   = 1'b0;
    exp_blink = 1'b0;
    for (int k = 1; k <= 1500; k++) begin
      @(negedge clk);
      wrap = 1'b0;
      if (prev_tick) begin
        started = 1'b1;
        if (eqh == 14) begin
          eqh = 0;
          if (eqv == 11) begin
            eqv  = 0;
            wrap = 1'b1;
          end else begin
            eqv++;
          end
        end else begin
          eqh++;
        end
      end
`ifdef VGA_BLINK_EN
      if (prev_fs) begin
        if (fcnt == 1) begin
          fcnt      = 0;
          exp_blink = ~exp_blink;
        end else begin
          fcnt++;
        end
      end
`endif
      check("s_tick", tick_s, (k % 2 == 0) ? 1 : 0);
      check("s_qh", qh_s, eqh);
      check("s_qv", qv_s, eqv);
      check("s_frame_start", fs_s, wrap);
      check("s_hsync", hs_s, started ? !(eqh >= 10 && eqh < 13) : 1);
      check("s_vsync", vs_s, started ? !(eqv >= 8 && eqv < 10) : 1);
      check("s_video", vid_s, started && eqh < 8 && eqv < 6);
      check("s_blink", blink_s, exp_blink);
      if (k == 800) check("blink_mid", blink_s, blink_hand);
      if (fs_s === 1'b1) fs_cnt++;
      prev_tick = tick_s;
      prev_fs   = fs_s;
    end
    check("frame_count", fs_cnt, 4);
    check("blink_end", blink_s, 0);
    check("blink_a_end", blink_a, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
